// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers of the 5-stage core.
//   - skid_state_e : occupancy state of the two-entry skid variant
//   - *_CTRL_W / *_DATA_W : control/payload widths per pipeline boundary
//   - EX/MEM named-field structs plus pack/unpack helpers to and from the
//     flat vectors carried by elastic_pipe_reg
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    localparam int IFID_CTRL_W  = 1;    // valid-instruction marker only
    localparam int IFID_DATA_W  = 96;   // instr, pc, pc_plus4
    localparam int IDEX_CTRL_W  = 16;
    localparam int IDEX_DATA_W  = 175;  // rd1, rd2, pc, imm_ext, pc_plus4, rs1, rs2, rd
    localparam int EXMEM_CTRL_W = 11;
    localparam int EXMEM_DATA_W = 133;  // pc, alu_result, write_data, imm_ext, rd
    localparam int MEMWB_CTRL_W = 3;
    localparam int MEMWB_DATA_W = 133;

    // Field order is the packing order: RegWrite ends up in the MSB.
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic [1:0] s_sel;
        logic [2:0] l_sel;
        logic       u_load;
        logic       alu_result_src;
    } exmem_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] imm_ext;
        logic [4:0]  rd;
    } exmem_data_t;

    function automatic logic [EXMEM_CTRL_W-1:0] pack_exmem_ctrl(input exmem_ctrl_t c);
        return c;
    endfunction

    function automatic exmem_ctrl_t unpack_exmem_ctrl(input logic [EXMEM_CTRL_W-1:0] v);
        return exmem_ctrl_t'(v);
    endfunction

    function automatic logic [EXMEM_DATA_W-1:0] pack_exmem_data(input exmem_data_t d);
        return d;
    endfunction

    function automatic exmem_data_t unpack_exmem_data(input logic [EXMEM_DATA_W-1:0] v);
        return exmem_data_t'(v);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of an elastic pipeline stage: valid bit + control + payload.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : squash (valid and control zeroed, payload too if CLEAR_DATA)
//   load       : capture d_ctrl/d_data and mark valid
//   drop       : mark invalid without touching stored bits (entry drained)
//   valid/ctrl/data : stored contents
// Priority: reset > clear > load > drop.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = EXMEM_CTRL_W,
    parameter int DATA_W     = EXMEM_DATA_W,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              drop,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= d_ctrl;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

    // Payload has no reset in the cheap variant; it only ever loads.
    generate
        if (CLEAR_DATA) begin : g_clr
            always_ff @(posedge clk) begin
                if (!rst_n || clear)
                    data <= '0;
                else if (load)
                    data <= d_data;
            end
        end else begin : g_hold
            always_ff @(posedge clk) begin
                if (rst_n && !clear && load)
                    data <= d_data;
            end
        end
    endgenerate

endmodule

// File: rtl/elastic_pipe_reg.sv
// Flow-controlled pipeline stage register with valid/ready handshake.
//   clk, rst_n         : clock, synchronous active-low reset
//   flush              : squash all held entries, blocks acceptance this cycle
//   in_valid/in_ready  : upstream handshake; in_ctrl/in_data sampled on accept
//   out_valid/out_ready: downstream handshake; out_ctrl is 0 whenever out_valid=0
//   occupancy          : number of entries held (0..2)
// SKID=0 : single slot, in_ready combinationally depends on out_ready.
// SKID=1 : main (head) + skid slot, in_ready depends only on state and flush.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = EXMEM_CTRL_W,
    parameter int DATA_W     = EXMEM_DATA_W,
    parameter bit SKID       = 1'b1,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic accept;
    logic emit;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    generate
        if (!SKID) begin : g_single
            logic              main_v;
            logic [CTRL_W-1:0] main_c;

            pipe_slot #(
                .CTRL_W    (CTRL_W),
                .DATA_W    (DATA_W),
                .CLEAR_DATA(CLEAR_DATA)
            ) u_main (
                .clk   (clk),
                .rst_n (rst_n),
                .clear (flush),
                .load  (accept),
                .drop  (emit && !accept),
                .d_ctrl(in_ctrl),
                .d_data(in_data),
                .valid (main_v),
                .ctrl  (main_c),
                .data  (out_data)
            );

            assign in_ready  = !flush && (!main_v || out_ready);
            assign out_valid = main_v;
            assign out_ctrl  = main_v ? main_c : '0;
            assign occupancy = {1'b0, main_v};

        end else begin : g_skid
            skid_state_e       state, state_nxt;
            logic              main_v, skid_v;
            logic [CTRL_W-1:0] main_c, skid_c;
            logic [DATA_W-1:0] skid_d;
            logic              main_load, main_drop, main_from_skid;
            logic              skid_load, skid_drop;
            logic [1:0]        occ;

            // State register
            always_ff @(posedge clk) begin
                if (!rst_n)
                    state <= EMPTY;
                else
                    state <= state_nxt;
            end

            // Next-state logic
            always_comb begin
                state_nxt = state;
                if (flush) begin
                    state_nxt = EMPTY;
                end else begin
                    case (state)
                        EMPTY: if (accept) state_nxt = ONE;
                        ONE: begin
                            if (accept && !emit)
                                state_nxt = TWO;
                            else if (emit && !accept)
                                state_nxt = EMPTY;
                        end
                        TWO:     if (emit) state_nxt = ONE;
                        default: state_nxt = EMPTY;
                    endcase
                end
            end

            // Output / slot-control logic. Flush is handled by the slot clear
            // input, which overrides every load/drop below.
            always_comb begin
                main_load      = 1'b0;
                main_drop      = 1'b0;
                main_from_skid = 1'b0;
                skid_load      = 1'b0;
                skid_drop      = 1'b0;
                occ            = 2'd0;
                case (state)
                    EMPTY: begin
                        main_load = accept;
                    end
                    ONE: begin
                        occ       = 2'd1;
                        main_load = accept && emit;
                        main_drop = emit && !accept;
                        skid_load = accept && !emit;
                    end
                    TWO: begin
                        occ            = 2'd2;
                        main_load      = emit;
                        main_from_skid = 1'b1;
                        skid_drop      = emit;
                    end
                    default: ;
                endcase
            end

            pipe_slot #(
                .CTRL_W    (CTRL_W),
                .DATA_W    (DATA_W),
                .CLEAR_DATA(CLEAR_DATA)
            ) u_main (
                .clk   (clk),
                .rst_n (rst_n),
                .clear (flush),
                .load  (main_load),
                .drop  (main_drop),
                .d_ctrl(main_from_skid ? skid_c : in_ctrl),
                .d_data(main_from_skid ? skid_d : in_data),
                .valid (main_v),
                .ctrl  (main_c),
                .data  (out_data)
            );

            pipe_slot #(
                .CTRL_W    (CTRL_W),
                .DATA_W    (DATA_W),
                .CLEAR_DATA(CLEAR_DATA)
            ) u_skid (
                .clk   (clk),
                .rst_n (rst_n),
                .clear (flush),
                .load  (skid_load),
                .drop  (skid_drop),
                .d_ctrl(in_ctrl),
                .d_data(in_data),
                .valid (skid_v),
                .ctrl  (skid_c),
                .data  (skid_d)
            );

            // Registered ready: no path from out_ready back to in_ready.
            assign in_ready  = !flush && !skid_v;
            assign out_valid = main_v;
            assign out_ctrl  = main_v ? main_c : '0;
            assign occupancy = occ;
        end
    endgenerate

endmodule

// File: tb/tb_elastic_pipe_reg.sv
module tb_elastic_pipe_reg;
    localparam int CW = 11;
    localparam int DW = 133;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    // s1: SKID=1 CLEAR_DATA=0, s0: SKID=0 CLEAR_DATA=0, sc: SKID=1 CLEAR_DATA=1
    logic          s1_ir, s1_ov, s0_ir, s0_ov, sc_ir, sc_ov;
    logic [CW-1:0] s1_oc, s0_oc, sc_oc;
    logic [DW-1:0] s1_od, s0_od, sc_od;
    logic [1:0]    s1_occ, s0_occ, sc_occ;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    elastic_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CLEAR_DATA(1'b0)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s1_ir),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s1_ov), .out_ready(out_ready),
        .out_ctrl(s1_oc), .out_data(s1_od), .occupancy(s1_occ));

    elastic_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .CLEAR_DATA(1'b0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s0_ir),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s0_ov), .out_ready(out_ready),
        .out_ctrl(s0_oc), .out_data(s0_od), .occupancy(s0_occ));

    elastic_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CLEAR_DATA(1'b1)) dut_sc (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(sc_ir),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(sc_ov), .out_ready(out_ready),
        .out_ctrl(sc_oc), .out_data(sc_od), .occupancy(sc_occ));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_reset;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_ctrl = 11'h7FF; in_data = 133'h1234;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (s1_ov !== 1'b0 || s1_oc !== '0 || s1_occ !== 2'd0) begin
                errors++;
                $display("FAIL reset_s1 cyc%0d: ov=%b oc=%h occ=%0d, want 0 0 0", i, s1_ov, s1_oc, s1_occ);
            end
            checks++;
            if (s0_ov !== 1'b0 || s0_oc !== '0 || s0_occ !== 2'd0) begin
                errors++;
                $display("FAIL reset_s0 cyc%0d: ov=%b oc=%h occ=%0d, want 0 0 0", i, s0_ov, s0_oc, s0_occ);
            end
        end
        checks++;
        if (sc_od !== '0) begin
            errors++;
            $display("FAIL reset_clear_data: od=%h want 0", sc_od);
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (s1_ir !== 1'b1 || s0_ir !== 1'b1 || sc_ir !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: s1=%b s0=%b sc=%b want 1 1 1", s1_ir, s0_ir, sc_ir);
        end
    endtask

    task automatic test_stream;
        quiet_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DW'(i); in_ctrl = CW'(i);
            tick();
            checks++;
            if (s1_ov !== 1'b1 || s1_od !== DW'(i) || s1_oc !== CW'(i) ||
                s1_occ !== 2'd1 || s1_ir !== 1'b1) begin
                errors++;
                $display("FAIL stream beat%0d: ov=%b od=%h oc=%h occ=%0d ir=%b, want 1 %h %h 1 1",
                         i, s1_ov, s1_od, s1_oc, s1_occ, s1_ir, DW'(i), CW'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (s1_ov !== 1'b0 || s1_oc !== '0 || s1_occ !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain: ov=%b oc=%h occ=%0d, want 0 0 0", s1_ov, s1_oc, s1_occ);
        end
    endtask

    task automatic test_backpressure;
        quiet_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 133'hA; in_ctrl = 11'h00A;
        tick();
        in_data = 133'hB; in_ctrl = 11'h00B;
        #1;
        checks++;
        if (s1_occ !== 2'd1 || s1_ir !== 1'b1 || s1_od !== 133'hA) begin
            errors++;
            $display("FAIL bp_one: occ=%0d ir=%b od=%h, want 1 1 a", s1_occ, s1_ir, s1_od);
        end
        tick();
        in_data = 133'hC; in_ctrl = 11'h00C;
        #1;
        checks++;
        if (s1_occ !== 2'd2 || s1_ir !== 1'b0 || s1_od !== 133'hA || s1_oc !== 11'h00A) begin
            errors++;
            $display("FAIL bp_two: occ=%0d ir=%b od=%h oc=%h, want 2 0 a 00a", s1_occ, s1_ir, s1_od, s1_oc);
        end
        tick();
        checks++;
        if (s1_occ !== 2'd2 || s1_od !== 133'hA) begin
            errors++;
            $display("FAIL bp_hold: occ=%0d od=%h, want 2 a", s1_occ, s1_od);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (s1_ov !== 1'b1 || s1_od !== 133'hA) begin
            errors++;
            $display("FAIL bp_emit_a: ov=%b od=%h, want 1 a", s1_ov, s1_od);
        end
        tick();
        checks++;
        if (s1_ov !== 1'b1 || s1_od !== 133'hB || s1_oc !== 11'h00B || s1_occ !== 2'd1 || s1_ir !== 1'b1) begin
            errors++;
            $display("FAIL bp_emit_b: ov=%b od=%h oc=%h occ=%0d ir=%b, want 1 b 00b 1 1",
                     s1_ov, s1_od, s1_oc, s1_occ, s1_ir);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (s1_ov !== 1'b1 || s1_od !== 133'hC || s1_occ !== 2'd1) begin
            errors++;
            $display("FAIL bp_emit_c: ov=%b od=%h occ=%0d, want 1 c 1", s1_ov, s1_od, s1_occ);
        end
        tick();
        checks++;
        if (s1_ov !== 1'b0 || s1_occ !== 2'd0) begin
            errors++;
            $display("FAIL bp_empty: ov=%b occ=%0d, want 0 0", s1_ov, s1_occ);
        end
    endtask

    task automatic test_flush;
        quiet_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 133'h11; in_ctrl = 11'h011;
        tick();
        in_data = 133'h22; in_ctrl = 11'h022;
        tick();
        checks++;
        if (s1_occ !== 2'd2) begin
            errors++;
            $display("FAIL flush_setup: occ=%0d want 2", s1_occ);
        end
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 11'h7FF; in_data = 133'h55; out_ready = 1'b1;
        #1;
        checks++;
        if (s1_ir !== 1'b0 || s0_ir !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: s1=%b s0=%b want 0 0", s1_ir, s0_ir);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (s1_occ !== 2'd0 || s1_ov !== 1'b0 || s1_oc !== '0) begin
            errors++;
            $display("FAIL flush_result: occ=%0d ov=%b oc=%h, want 0 0 0", s1_occ, s1_ov, s1_oc);
        end
        tick();
        checks++;
        if (s1_ov !== 1'b0 || s1_occ !== 2'd0) begin
            errors++;
            $display("FAIL flush_no_accept: ov=%b occ=%0d, want 0 0", s1_ov, s1_occ);
        end
    endtask

    task automatic test_skid0_equiv;
        logic          ref_v;
        logic [CW-1:0] ref_c;
        logic [DW-1:0] ref_d;
        logic [159:0]  rnd;
        quiet_reset();
        ref_v = 1'b0; ref_c = '0; ref_d = '0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            in_valid = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 9) == 0);
            in_ctrl  = CW'($urandom);
            in_data  = rnd[DW-1:0];
            #1;
            checks++;
            if (s0_ir !== !flush) begin
                errors++;
                $display("FAIL equiv_in_ready cyc%0d: ir=%b want %b", cyc, s0_ir, !flush);
            end
            if (flush) begin
                ref_v = 1'b0; ref_c = '0;
            end else if (in_valid) begin
                ref_v = 1'b1; ref_c = in_ctrl; ref_d = in_data;
            end else begin
                ref_v = 1'b0;
            end
            tick();
            checks++;
            if (s0_ov !== ref_v || s0_oc !== (ref_v ? ref_c : '0) ||
                s0_occ !== {1'b0, ref_v} || (ref_v && s0_od !== ref_d)) begin
                errors++;
                $display("FAIL equiv_out cyc%0d: ov=%b oc=%h occ=%0d od=%h, want %b %h %0d %h",
                         cyc, s0_ov, s0_oc, s0_occ, s0_od, ref_v, ref_v ? ref_c : '0,
                         {1'b0, ref_v}, ref_d);
            end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_clear_data;
        logic [DW-1:0] dead;
        dead = {5'h0, 128'hDEADBEEF_CAFEF00D_DEADBEEF_12345678};
        quiet_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = dead; in_ctrl = 11'h3C3;
        tick();
        checks++;
        if (sc_od !== dead || s1_od !== dead) begin
            errors++;
            $display("FAIL cd_load: sc=%h s1=%h want %h", sc_od, s1_od, dead);
        end
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (sc_od !== '0 || sc_ov !== 1'b0) begin
            errors++;
            $display("FAIL cd_cleared: od=%h ov=%b want 0 0", sc_od, sc_ov);
        end
        checks++;
        if (s1_od !== dead || s1_ov !== 1'b0 || s1_oc !== '0) begin
            errors++;
            $display("FAIL cd_held: od=%h ov=%b oc=%h want %h 0 0", s1_od, s1_ov, s1_oc, dead);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_skid0_equiv();
        test_clear_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
Parametrised, flow-controlled pipeline stage register for the 5-stage core. It replaces fixed stage registers with one generic block. Control and payload fields are carried as packed vectors with a valid/ready handshake. An optional 2-entry skid mode breaks the combinational ready path. Flush squashes contents and zeroes control, so bubbles never assert write enables downstream. Intended first use is the EX/MEM boundary, then the IF/ID, ID/EX and MEM/WB boundaries.

Parameters:
CTRL_W, 11, width of control field; zeroed on flush and on bubbles
DATA_W, 133, width of payload field (PC, operands, results, Rd)
SKID, 1, 0 = single-entry register with combinational in_ready; 1 = two-entry skid buffer with registered in_ready
CLEAR_DATA, 0, 1 = payload also zeroed on reset/flush; 0 = payload holds its last value (saves area)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
flush  in  1  synchronous squash of all held entries (hazard unit / branch mispredict)
in_valid  in  1  upstream entry present
in_ready  out  1  stage can accept this cycle
in_ctrl  in  CTRL_W  upstream control bits
in_data  in  DATA_W  upstream payload
out_valid  out  1  head entry present
out_ready  in  1  downstream accepts head this cycle
out_ctrl  out  CTRL_W  head control bits; forced to 0 when out_valid = 0
out_data  out  DATA_W  head payload
occupancy  out  2  entries held (0..1 if SKID=0, 0..2 if SKID=1)

Behaviour:
- Handshake and ordering:
  - Accept when in_valid && in_ready. Emit when out_valid && out_ready.
  - Strict FIFO order. No entry is duplicated or dropped except by flush.
  - in_valid may assert without waiting for in_ready. in_ctrl/in_data are sampled only on accept.
- Latency: an accepted entry appears on out_* the next cycle (1-cycle latency in both modes).
- Reset: rst_n low at a clock edge clears all state on that edge, overriding flush and any handshake.
  - After reset: out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
  - out_data=0 after reset if CLEAR_DATA=1, otherwise undefined/held.
- Flush (rst_n high):
  - All entries are invalidated and occupancy becomes 0 on that edge.
  - in_ready is forced to 0 combinationally while flush=1, so no beat is accepted in a flush cycle.
  - Any out_ready in that cycle is irrelevant.
  - Stored control is zeroed. Payload is zeroed only when CLEAR_DATA=1.
- SKID=0:
  - in_ready = !flush && (!out_valid || out_ready).
  - With out_ready tied 1, the block is exactly a clear-able stage register.
- SKID=1:
  - Storage is a main slot (head) and a skid slot. in_ready = !flush && !skid_valid (purely registered apart from flush).
  - States:
    - EMPTY (occ 0): accept -> ONE.
    - ONE (occ 1):
      - accept && emit -> ONE; main reloads.
      - accept && !emit -> TWO; incoming goes to skid.
      - emit && !accept -> EMPTY.
      - otherwise hold.
    - TWO (occ 2): in_ready=0.
      - emit -> ONE; skid moves to main, skid cleared.
      - otherwise hold.
  - Any state -> EMPTY on flush.
- Bubbles: whenever out_valid=0, out_ctrl reads 0 regardless of stored bits.
- Width rules: widths are fixed by parameters. No arithmetic. occupancy is 2 bits in both modes.

Decomposition:
- Shared package pipe_pkg holds:
  - the skid state enum (EMPTY, ONE, TWO);
  - the per-boundary width constants (EXMEM_CTRL_W=11, EXMEM_DATA_W=133, plus IFID/IDEX/MEMWB equivalents);
  - pack/unpack functions mapping named EX/MEM fields to the vectors. Packing order: ctrl = {RegWrite, ResultSrc, MemWrite, s_sel, l_sel, u_load, ALUResultSrc}.
- One natural sub-module, pipe_slot:
  - a single valid + ctrl + data register with load, clear and CLEAR_DATA behaviour;
  - instantiated once for SKID=0 and twice for SKID=1.

Test Plan:
1. Reset:
   - Hold rst_n=0 two cycles with in_valid=1 and flush=1 -> out_valid=0, out_ctrl=0, occupancy=0.
   - First cycle after release -> in_ready=1.
2. Streaming, SKID=1, out_ready=1:
   - in_valid=1 with data 0x1..0x8 on consecutive cycles -> same sequence on out_data one cycle later.
   - occupancy stays 1; in_ready stays 1.
3. Backpressure:
   - Accept A, B with out_ready=0 -> occupancy=2, in_ready=0; C is held off upstream.
   - Raise out_ready -> A, B, C emitted in order with no gaps and no loss.
4. Flush:
   - Flush in TWO with in_valid=1 and in_ctrl=0x7FF -> next cycle occupancy=0, out_valid=0, out_ctrl=0.
   - The incoming beat is not accepted (in_ready=0 that cycle).
5. SKID=0 equivalence:
   - out_ready=1, random in_valid, and flush on 10% of cycles -> out_* matches a single reference register cleared on flush, cycle for cycle.
6. CLEAR_DATA:
   - With CLEAR_DATA=1, a flush after loading data 0xDEAD... -> out_data=0.
   - With CLEAR_DATA=0 -> out_data retains the old value while out_valid=0.
